param_bus_datapath: RTL and testbench

PARAM_BUS_DATAPATH -- requirements
Module: param_bus_datapath

---
 rtl/cpu_pkg.sv | 19 +
 rtl/gp_reg_file.sv | 28 ++
 rtl/param_bus_datapath.sv | 139 +++++++++++++
 tb/tb_param_bus_datapath.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, FSM states and instruction field offsets for the bus datapath
package cpu_pkg;
   localparam logic [2:0] OP_MV  = 3'b000;
   localparam logic [2:0] OP_MVI = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_NOP = 3'b101;
   typedef enum logic [2:0] {S_IDLE, S_DECODE, S_IMM, S_T2, S_T3} state_t;
   function automatic int op_lsb(input int data_w);
      return data_w - 3;
   endfunction
   function automatic int rx_lsb(input int data_w, input int sel_w);
      return data_w - 3 - sel_w;
   endfunction
   function automatic int ry_lsb(input int data_w, input int sel_w);
      return data_w - 3 - 2 * sel_w;
   endfunction
endpackage

// File: rtl/gp_reg_file.sv
// gp_reg_file: general registers, one sync write port, two comb read ports and a debug read port
module gp_reg_file #(
   parameter int DATA_W = 16,
   parameter int NUM_REGS = 8,
   localparam int SEL_W = $clog2(NUM_REGS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we_i,
   input  logic [SEL_W-1:0]  waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [SEL_W-1:0]  raddr_a_i,
   input  logic [SEL_W-1:0]  raddr_b_i,
   input  logic [SEL_W-1:0]  dbg_sel_i,
   output logic [DATA_W-1:0] rdata_a_o,
   output logic [DATA_W-1:0] rdata_b_o,
   output logic [DATA_W-1:0] dbg_data_o
);
   logic [DATA_W-1:0] regs_q [NUM_REGS];
   always_ff @(posedge clk)
      if (rst)
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      else if (we_i)
         regs_q[waddr_i] <= wdata_i;
   assign rdata_a_o  = regs_q[raddr_a_i];
   assign rdata_b_o  = regs_q[raddr_b_i];
   assign dbg_data_o = regs_q[dbg_sel_i];
endmodule

// File: rtl/param_bus_datapath.sv
// param_bus_datapath: multi-cycle register/ALU datapath around a one-hot-select internal bus
module param_bus_datapath
   import cpu_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int NUM_REGS = 8,
   localparam int REG_SEL_W = $clog2(NUM_REGS)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_W-1:0]    instr_in,
   input  logic                 instr_valid,
   output logic                 instr_ready,
   input  logic [DATA_W-1:0]    imm_in,
   input  logic                 imm_valid,
   output logic                 imm_ready,
   output logic                 done,
   output logic                 illegal,
   output logic [DATA_W-1:0]    bus_out,
   output logic                 flag_z,
   output logic                 flag_c,
   input  logic [REG_SEL_W-1:0] dbg_sel,
   output logic [DATA_W-1:0]    dbg_data
);
   localparam int OP_LSB = op_lsb(DATA_W);
   localparam int RX_LSB = rx_lsb(DATA_W, REG_SEL_W);
   localparam int RY_LSB = ry_lsb(DATA_W, REG_SEL_W);
   if (NUM_REGS < 2 || (NUM_REGS & (NUM_REGS - 1)) != 0 || DATA_W < 3 + 2 * REG_SEL_W) begin : g_bad_params
      $error("param_bus_datapath: invalid DATA_W/NUM_REGS combination");
   end
   state_t state_q, state_d, st;
   logic [DATA_W-1:0] ir_q, a_q, g_q, rx_data, ry_data, bus;
   logic [DATA_W:0] alu;
   logic z_q, c_q, sel_x, sel_y, sel_imm, sel_g, we, load_a, load_g, unused_ir;
   logic [2:0] opcode;
   logic [REG_SEL_W-1:0] rx, ry;
   assign opcode = ir_q[OP_LSB +: 3];
   assign rx = ir_q[RX_LSB +: REG_SEL_W];
   assign ry = ir_q[RY_LSB +: REG_SEL_W];
   assign unused_ir = ^ir_q;
   // Reset forces the IDLE view combinationally so no done/illegal/write leaks out mid-instruction
   assign st = rst ? S_IDLE : state_q;
   always_comb begin
      state_d = st;
      instr_ready = 1'b0;
      imm_ready = 1'b0;
      done = 1'b0;
      illegal = 1'b0;
      sel_x = 1'b0;
      sel_y = 1'b0;
      sel_imm = 1'b0;
      sel_g = 1'b0;
      we = 1'b0;
      load_a = 1'b0;
      load_g = 1'b0;
      case (st)
         S_IDLE: begin
            instr_ready = 1'b1;
            state_d = instr_valid ? S_DECODE : S_IDLE;
         end
         S_DECODE: begin
            state_d = S_IDLE;
            if (opcode == OP_MV) begin
               sel_y = 1'b1;
               we = 1'b1;
               done = 1'b1;
            end else if (opcode == OP_NOP)
               done = 1'b1;
            else if (opcode == OP_MVI)
               state_d = S_IMM;
            else if (opcode inside {OP_ADD, OP_SUB, OP_XOR}) begin
               sel_x = 1'b1;
               load_a = 1'b1;
               state_d = S_T2;
            end else
               illegal = 1'b1;
         end
         S_IMM: begin
            imm_ready = 1'b1;
            sel_imm = imm_valid;
            we = imm_valid;
            done = imm_valid;
            state_d = imm_valid ? S_IDLE : S_IMM;
         end
         S_T2: begin
            sel_y = 1'b1;
            load_g = 1'b1;
            state_d = S_T3;
         end
         S_T3: begin
            sel_g = 1'b1;
            we = 1'b1;
            done = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end
   assign bus = ({DATA_W{sel_x}} & rx_data) | ({DATA_W{sel_y}} & ry_data)
              | ({DATA_W{sel_imm}} & imm_in) | ({DATA_W{sel_g}} & g_q);
   // The MSB of the widened result is carry for ADD and borrow for SUB
   assign alu = opcode == OP_ADD ? {1'b0, a_q} + {1'b0, bus}
              : opcode == OP_SUB ? {1'b0, a_q} - {1'b0, bus}
              : {1'b0, a_q ^ bus};
   always_ff @(posedge clk)
      if (rst) begin
         state_q <= S_IDLE;
         ir_q <= '0;
         a_q <= '0;
         g_q <= '0;
         z_q <= 1'b0;
         c_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (instr_ready && instr_valid) ir_q <= instr_in;
         if (load_a) a_q <= bus;
         if (load_g) begin
            g_q <= alu[DATA_W-1:0];
            z_q <= alu[DATA_W-1:0] == '0;
            c_q <= alu[DATA_W];
         end
      end
   gp_reg_file #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) u_regs (
      .clk(clk),
      .rst(rst),
      .we_i(we),
      .waddr_i(rx),
      .wdata_i(bus),
      .raddr_a_i(rx),
      .raddr_b_i(ry),
      .dbg_sel_i(dbg_sel),
      .rdata_a_o(rx_data),
      .rdata_b_o(ry_data),
      .dbg_data_o(dbg_data)
   );
   assign bus_out = bus;
   assign flag_z = z_q;
   assign flag_c = c_q;
endmodule

// File: tb/tb_param_bus_datapath.sv
// tb_param_bus_datapath: table-driven check of the bus datapath plus reset and handshake corner cases
module tb_param_bus_datapath;
   import cpu_pkg::*;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst, instr_valid, instr_ready, imm_valid, imm_ready, done, illegal, flag_z, flag_c;
   logic [15:0] instr_in, imm_in, bus_out, dbg_data;
   logic [2:0] dbg_sel;
   logic rst2, iv2, ir2, imv2, imr2, done2, ill2, z2, c2;
   logic [31:0] instr2, imm2, bus2, ddat2;
   logic [3:0] dsel2;
   param_bus_datapath u_dut (
      .clk(clk), .rst(rst), .instr_in(instr_in), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .imm_in(imm_in), .imm_valid(imm_valid), .imm_ready(imm_ready), .done(done), .illegal(illegal),
      .bus_out(bus_out), .flag_z(flag_z), .flag_c(flag_c), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
   );
   param_bus_datapath #(.DATA_W(32), .NUM_REGS(16)) u_dut32 (
      .clk(clk), .rst(rst2), .instr_in(instr2), .instr_valid(iv2), .instr_ready(ir2),
      .imm_in(imm2), .imm_valid(imv2), .imm_ready(imr2), .done(done2), .illegal(ill2),
      .bus_out(bus2), .flag_z(z2), .flag_c(c2), .dbg_sel(dsel2), .dbg_data(ddat2)
   );
   int checks = 0, errors = 0;
   typedef struct {
      logic [2:0] op;
      logic [2:0] rx, ry;
      logic [15:0] imm;
      int lat, ill;
      logic [2:0] cr;
      logic [15:0] val;
      logic z, c, wr;
   } vec_t;
   vec_t v[16];
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask
   function automatic logic [15:0] enc(input logic [2:0] op, input logic [2:0] rx, input logic [2:0] ry);
      return {op, rx, ry, 7'b0};
   endfunction
   function automatic logic [31:0] enc2(input logic [2:0] op, input logic [3:0] rx, input logic [3:0] ry);
      return {op, rx, ry, 21'b0};
   endfunction
   function automatic vec_t mkv(input logic [2:0] op, input logic [2:0] rx, input logic [2:0] ry, input logic [15:0] imm,
                                input int lat, input int ill, input logic [2:0] cr, input logic [15:0] val,
                                input logic z, input logic c, input logic wr);
      vec_t r;
      r.op = op; r.rx = rx; r.ry = ry; r.imm = imm; r.lat = lat; r.ill = ill;
      r.cr = cr; r.val = val; r.z = z; r.c = c; r.wr = wr;
      return r;
   endfunction
   task automatic exec(input logic [15:0] ins, input logic [15:0] imm, output int lat, output int ill, output logic [15:0] bd);
      lat = 0; ill = 0; bd = '0;
      @(negedge clk);
      instr_in = ins; instr_valid = 1'b1;
      @(posedge clk);
      #1 instr_valid = 1'b0;
      for (int cyc = 1; cyc <= 5 && lat == 0; cyc++) begin
         @(negedge clk);
         if (imm_ready) begin imm_in = imm; imm_valid = 1'b1; #1; end
         if (illegal) ill++;
         if (done) begin lat = cyc; bd = bus_out; end
      end
      if (lat != 0) begin
         @(posedge clk);
         #1 imm_valid = 1'b0;
         @(negedge clk);
      end
   endtask
   task automatic exec2(input logic [31:0] ins, input logic [31:0] imm, output int lat);
      lat = 0;
      @(negedge clk);
      instr2 = ins; iv2 = 1'b1;
      @(posedge clk);
      #1 iv2 = 1'b0;
      for (int cyc = 1; cyc <= 5 && lat == 0; cyc++) begin
         @(negedge clk);
         if (imr2) begin imm2 = imm; imv2 = 1'b1; #1; end
         if (done2) lat = cyc;
      end
      @(posedge clk);
      #1 imv2 = 1'b0;
      @(negedge clk);
   endtask
   initial begin
      int lat, ill;
      logic [15:0] bd;
      v[0]  = mkv(OP_MVI, 1, 0, 16'h1234, 2, 0, 1, 16'h1234, 0, 0, 1);
      v[1]  = mkv(OP_MVI, 2, 0, 16'h0001, 2, 0, 2, 16'h0001, 0, 0, 1);
      v[2]  = mkv(OP_MVI, 1, 0, 16'hFFFF, 2, 0, 1, 16'hFFFF, 0, 0, 1);
      v[3]  = mkv(OP_ADD, 1, 2, 16'h0000, 3, 0, 1, 16'h0000, 1, 1, 1);
      v[4]  = mkv(OP_MVI, 3, 0, 16'h0005, 2, 0, 3, 16'h0005, 1, 1, 1);
      v[5]  = mkv(OP_MVI, 4, 0, 16'h0007, 2, 0, 4, 16'h0007, 1, 1, 1);
      v[6]  = mkv(OP_SUB, 3, 4, 16'h0000, 3, 0, 3, 16'hFFFE, 0, 1, 1);
      v[7]  = mkv(OP_MV,  5, 3, 16'h0000, 1, 0, 5, 16'hFFFE, 0, 1, 1);
      v[8]  = mkv(OP_XOR, 3, 3, 16'h0000, 3, 0, 3, 16'h0000, 1, 0, 1);
      v[9]  = mkv(OP_ADD, 5, 5, 16'h0000, 3, 0, 5, 16'hFFFC, 0, 1, 1);
      v[10] = mkv(OP_NOP, 5, 0, 16'h0000, 1, 0, 5, 16'hFFFC, 0, 1, 0);
      v[11] = mkv(3'b111, 5, 1, 16'h0000, 0, 1, 5, 16'hFFFC, 0, 1, 0);
      v[12] = mkv(3'b110, 2, 4, 16'h0000, 0, 1, 2, 16'h0001, 0, 1, 0);
      v[13] = mkv(OP_SUB, 2, 2, 16'h0000, 3, 0, 2, 16'h0000, 1, 0, 1);
      v[14] = mkv(OP_ADD, 4, 2, 16'h0000, 3, 0, 4, 16'h0007, 0, 0, 1);
      v[15] = mkv(OP_MV,  0, 4, 16'h0000, 1, 0, 0, 16'h0007, 0, 0, 1);
      rst = 1'b1; instr_in = '0; instr_valid = 1'b0; imm_in = '0; imm_valid = 1'b0; dbg_sel = '0;
      rst2 = 1'b1; instr2 = '0; iv2 = 1'b0; imm2 = '0; imv2 = 1'b0; dsel2 = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst instr_ready", instr_ready, 1);
      chk("rst imm_ready", imm_ready, 0);
      chk("rst done", done, 0);
      chk("rst illegal", illegal, 0);
      chk("rst bus_out", bus_out, 0);
      chk("rst flags", {flag_z, flag_c}, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      for (int r = 0; r < 8; r++) begin
         dbg_sel = 3'(r); #1;
         chk($sformatf("rst R%0d", r), dbg_data, 0);
      end
      for (int i = 0; i < 16; i++) begin
         exec(enc(v[i].op, v[i].rx, v[i].ry), v[i].imm, lat, ill, bd);
         chk($sformatf("v%0d latency", i), lat, v[i].lat);
         chk($sformatf("v%0d illegal pulses", i), ill, v[i].ill);
         dbg_sel = v[i].cr; #1;
         chk($sformatf("v%0d R%0d", i, v[i].cr), dbg_data, v[i].val);
         chk($sformatf("v%0d flag_z", i), flag_z, v[i].z);
         chk($sformatf("v%0d flag_c", i), flag_c, v[i].c);
         chk($sformatf("v%0d instr_ready", i), instr_ready, 1);
         if (v[i].wr) chk($sformatf("v%0d bus at done", i), bd, v[i].val);
      end
      @(negedge clk);
      instr_in = enc(OP_MVI, 6, 0); instr_valid = 1'b1;
      @(posedge clk);
      #1 instr_in = enc(OP_MV, 7, 1);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk($sformatf("hold%0d imm_ready", c), imm_ready, c != 0);
         chk($sformatf("hold%0d done", c), done, 0);
         chk($sformatf("hold%0d instr_ready", c), instr_ready, 0);
      end
      instr_valid = 1'b0; imm_in = 16'hABCD; imm_valid = 1'b1; #1;
      chk("mvi done", done, 1);
      chk("mvi bus", bus_out, 16'hABCD);
      @(posedge clk);
      #1 imm_valid = 1'b0;
      @(negedge clk);
      dbg_sel = 3'd6; #1;
      chk("mvi R6", dbg_data, 16'hABCD);
      dbg_sel = 3'd7; #1;
      chk("ignored MV R7", dbg_data, 0);
      imm_in = 16'h5555; imm_valid = 1'b1;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         chk($sformatf("idle imm%0d imm_ready", c), imm_ready, 0);
         chk($sformatf("idle imm%0d done", c), done, 0);
         chk($sformatf("idle imm%0d bus", c), bus_out, 0);
      end
      imm_valid = 1'b0;
      dbg_sel = 3'd6; #1;
      chk("idle imm R6", dbg_data, 16'hABCD);
      exec(enc(OP_MVI, 1, 0), 16'hFFFF, lat, ill, bd);
      exec(enc(OP_MVI, 2, 0), 16'h0001, lat, ill, bd);
      @(negedge clk);
      instr_in = enc(OP_ADD, 1, 2); instr_valid = 1'b1;
      @(posedge clk);
      #1 instr_valid = 1'b0;
      @(negedge clk);
      chk("t2rst decode done", done, 0);
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("t2rst done", done, 0);
      chk("t2rst illegal", illegal, 0);
      chk("t2rst instr_ready", instr_ready, 1);
      chk("t2rst bus", bus_out, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk($sformatf("t2rst after%0d done", c), done, 0);
         chk($sformatf("t2rst after%0d instr_ready", c), instr_ready, 1);
      end
      for (int r = 0; r < 8; r++) begin
         dbg_sel = 3'(r); #1;
         chk($sformatf("t2rst R%0d", r), dbg_data, 0);
      end
      chk("t2rst flags", {flag_z, flag_c}, 0);
      @(posedge clk);
      #1 rst2 = 1'b0;
      exec2(enc2(OP_MVI, 1, 0), 32'hFFFF_FFFF, lat);
      chk("w32 mvi latency", lat, 2);
      exec2(enc2(OP_MVI, 2, 0), 32'h0000_0001, lat);
      dsel2 = 4'd1; #1;
      chk("w32 R1 pre", ddat2, 32'hFFFF_FFFF);
      exec2(enc2(OP_ADD, 1, 2), 32'h0, lat);
      chk("w32 add latency", lat, 3);
      #1 chk("w32 R1", ddat2, 32'h0);
      chk("w32 flag_z", z2, 1);
      chk("w32 flag_c", c2, 1);
      exec2(enc2(OP_MVI, 15, 0), 32'h8000_0001, lat);
      exec2(enc2(OP_ADD, 15, 15), 32'h0, lat);
      dsel2 = 4'd15; #1;
      chk("w32 R15 double", ddat2, 32'h0000_0002);
      chk("w32 R15 flags", {z2, c2}, 2'b01);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
